// File: rtl/key_debounce_pkg.sv
// Shared constants for the key conditioning path: FSM encoding, 50 MHz
// default timing and a constant clog2 helper for counter widths.
package key_debounce_pkg;

   localparam logic [1:0] ST_RELEASED     = 2'd0;
   localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
   localparam logic [1:0] ST_PRESSED      = 2'd2;
   localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

   localparam int unsigned DEF_KEY_NUM         = 4;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms at 50 MHz
   localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;  // 1 s at 50 MHz
   localparam int unsigned DEF_ACTIVE_LOW      = 1;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned x = value - 1; x > 0; x = x >> 1) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM, press/release/long
// event pulses. All outputs are registered.
module key_debounce_ch
   import key_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int unsigned ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
   input  logic clk,
   input  logic rstn,
   input  logic key_raw,
   output logic state,
   output logic press,
   output logic rel,
   output logic long
);

   localparam int unsigned DB_W = clog2(DEBOUNCE_CYCLES);
   localparam int unsigned LG_W = clog2(LONG_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);
   localparam logic [LG_W-1:0] LG_PRE  = LG_W'(LONG_CYCLES - 2);
   localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic            sync1;
   logic            sync2;
   logic            pressed_c;
   logic [1:0]      fsm;
   logic [1:0]      fsm_nxt;
   logic [DB_W-1:0] db_cnt;
   logic [DB_W-1:0] db_cnt_nxt;
   logic [LG_W-1:0] lg_cnt;
   logic [LG_W-1:0] lg_cnt_nxt;
   logic            state_nxt;
   logic            press_nxt;
   logic            rel_nxt;
   logic            long_nxt;

   // Synchronizer resets to the idle pin level so reset never looks like a press
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= IDLE_LVL;
         sync2 <= IDLE_LVL;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   assign pressed_c = sync2 ^ IDLE_LVL;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fsm    <= ST_RELEASED;
         db_cnt <= '0;
         lg_cnt <= '0;
         state  <= 1'b0;
         press  <= 1'b0;
         rel    <= 1'b0;
         long   <= 1'b0;
      end else begin
         fsm    <= fsm_nxt;
         db_cnt <= db_cnt_nxt;
         lg_cnt <= lg_cnt_nxt;
         state  <= state_nxt;
         press  <= press_nxt;
         rel    <= rel_nxt;
         long   <= long_nxt;
      end
   end

   always_comb begin
      fsm_nxt    = fsm;
      db_cnt_nxt = db_cnt;
      lg_cnt_nxt = lg_cnt;
      state_nxt  = state;
      press_nxt  = 1'b0;
      rel_nxt    = 1'b0;
      long_nxt   = 1'b0;
      case (fsm)
         ST_RELEASED: begin
            if (pressed_c) begin
               fsm_nxt    = ST_WAIT_PRESS;
               db_cnt_nxt = '0;
            end
         end
         ST_WAIT_PRESS: begin
            if (!pressed_c) begin
               fsm_nxt    = ST_RELEASED;
               db_cnt_nxt = '0;
            end else if (db_cnt == DB_LAST) begin
               fsm_nxt    = ST_PRESSED;
               state_nxt  = 1'b1;
               press_nxt  = 1'b1;
               lg_cnt_nxt = '0;
            end else begin
               db_cnt_nxt = db_cnt + DB_W'(1);
            end
         end
         ST_PRESSED: begin
            // long_cnt saturates at LG_LAST; the pulse marks only the arrival there
            if (!pressed_c) begin
               fsm_nxt    = ST_WAIT_RELEASE;
               db_cnt_nxt = '0;
            end else if (lg_cnt != LG_LAST) begin
               lg_cnt_nxt = lg_cnt + LG_W'(1);
               long_nxt   = (lg_cnt == LG_PRE);
            end
         end
         ST_WAIT_RELEASE: begin
            // long_cnt is kept so release bounce cannot re-arm the long pulse
            if (pressed_c) begin
               fsm_nxt = ST_PRESSED;
            end else if (db_cnt == DB_LAST) begin
               fsm_nxt   = ST_RELEASED;
               state_nxt = 1'b0;
               rel_nxt   = 1'b1;
            end else begin
               db_cnt_nxt = db_cnt + DB_W'(1);
            end
         end
         default: begin
            fsm_nxt = ST_RELEASED;
         end
      endcase
   end

endmodule

// File: rtl/key_debounce.sv
// Board push-key conditioner: KEY_NUM independent debounce channels giving
// clean key levels plus single-cycle press/release/long-press pulses.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int unsigned KEY_NUM         = DEF_KEY_NUM,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int unsigned ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [KEY_NUM-1:0] key_in,
   output logic [KEY_NUM-1:0] key_state,
   output logic [KEY_NUM-1:0] key_press,
   output logic [KEY_NUM-1:0] key_release,
   output logic [KEY_NUM-1:0] key_long
);

   for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_ch (
         .clk     (clk),
         .rstn    (rstn),
         .key_raw (key_in[i]),
         .state   (key_state[i]),
         .press   (key_press[i]),
         .rel     (key_release[i]),
         .long    (key_long[i])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with KEY_NUM=2, DEBOUNCE_CYCLES=8,
// LONG_CYCLES=32, ACTIVE_LOW=1; edge numbers are counted from the input change.
module tb_key_debounce;

   logic       clk;
   logic       rstn;
   logic [1:0] key_in;
   logic [1:0] key_state;
   logic [1:0] key_press;
   logic [1:0] key_release;
   logic [1:0] key_long;

   int checks;
   int errors;
   int tot_press [2];
   int tot_rel   [2];
   int tot_long  [2];
   int viol;

   key_debounce #(
      .KEY_NUM         (2),
      .DEBOUNCE_CYCLES (8),
      .LONG_CYCLES     (32),
      .ACTIVE_LOW      (1)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .key_in      (key_in),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse totals and same-cycle overlap count, sampled mid-cycle
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         tot_press[k] += int'(key_press[k]);
         tot_rel[k]   += int'(key_release[k]);
         tot_long[k]  += int'(key_long[k]);
         if (int'(key_press[k]) + int'(key_release[k]) + int'(key_long[k]) > 1) viol++;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int pulses(input int k);
      return tot_press[k] + tot_rel[k] + tot_long[k];
   endfunction

   // Step n edges, sampling key k 1 time unit after each edge
   task automatic watch(input int n, input int k,
                        output int fp, output int fr, output int fl,
                        output int np, output int nr, output int nl, output int nst);
      fp = -1; fr = -1; fl = -1;
      np = 0;  nr = 0;  nl = 0; nst = 0;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         if (key_press[k])   begin np++; if (fp < 0) fp = i; end
         if (key_release[k]) begin nr++; if (fr < 0) fr = i; end
         if (key_long[k])    begin nl++; if (fl < 0) fl = i; end
         nst += int'(key_state[k]);
      end
   endtask

   initial begin
      int fp, fr, fl, np, nr, nl, nst;
      int snap, st_bad, acc_p, acc_r, acc_l, acc_st;

      checks = 0;
      errors = 0;
      rstn   = 1'b0;
      key_in = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state",   int'(key_state),   0);
      chk("rst_press",   int'(key_press),   0);
      chk("rst_release", int'(key_release), 0);
      chk("rst_long",    int'(key_long),    0);
      rstn = 1'b1;

      snap = pulses(0) + pulses(1);
      st_bad = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (key_state != 2'b00) st_bad++;
      end
      chk("idle_pulses", pulses(0) + pulses(1) - snap, 0);
      chk("idle_state", st_bad, 0);

      // Clean press then release of key 0
      snap = pulses(1);
      key_in[0] = 1'b0;
      watch(20, 0, fp, fr, fl, np, nr, nl, nst);
      chk("clean_press_edge", fp, 11);
      chk("clean_press_cnt", np, 1);
      chk("clean_state_cycles", nst, 10);
      chk("clean_key1_quiet", pulses(1) - snap, 0);
      chk("clean_key1_state", int'(key_state[1]), 0);
      key_in[0] = 1'b1;
      watch(20, 0, fp, fr, fl, np, nr, nl, nst);
      chk("clean_rel_edge", fr, 11);
      chk("clean_rel_cnt", nr, 1);
      chk("clean_no_long", nl, 0);
      chk("clean_state_end", int'(key_state[0]), 0);

      // Bounce: 3 low / 2 high for 40 cycles, then stable low
      acc_p = 0; acc_r = 0; acc_st = 0;
      for (int p = 0; p < 8; p++) begin
         key_in[0] = 1'b0;
         watch(3, 0, fp, fr, fl, np, nr, nl, nst);
         acc_p += np; acc_r += nr; acc_st += nst;
         key_in[0] = 1'b1;
         watch(2, 0, fp, fr, fl, np, nr, nl, nst);
         acc_p += np; acc_r += nr; acc_st += nst;
      end
      chk("bounce_no_press", acc_p, 0);
      chk("bounce_no_rel", acc_r, 0);
      chk("bounce_state", acc_st, 0);
      key_in[0] = 1'b0;
      watch(20, 0, fp, fr, fl, np, nr, nl, nst);
      chk("bounce_press_edge", fp, 11);
      chk("bounce_press_cnt", np, 1);
      key_in[0] = 1'b1;
      watch(20, 0, fp, fr, fl, np, nr, nl, nst);
      chk("bounce_rel_edge", fr, 11);

      // Long press on key 1
      snap = pulses(0);
      key_in[1] = 1'b0;
      watch(60, 1, fp, fr, fl, np, nr, nl, nst);
      chk("long_press_edge", fp, 11);
      chk("long_press_cnt", np, 1);
      chk("long_edge", fl, 42);
      chk("long_cnt", nl, 1);
      chk("long_state_cycles", nst, 50);
      chk("long_key0_quiet", pulses(0) - snap, 0);
      key_in[1] = 1'b1;
      watch(20, 1, fp, fr, fl, np, nr, nl, nst);
      chk("long_rel_edge", fr, 11);
      chk("long_rel_cnt", nr, 1);
      chk("long_rel_no_long", nl, 0);
      chk("long_rel_state", int'(key_state[1]), 0);

      // Release bounce after long: 4-cycle high glitches while held
      key_in[1] = 1'b0;
      watch(45, 1, fp, fr, fl, np, nr, nl, nst);
      chk("glitch_pre_press", fp, 11);
      chk("glitch_pre_long", fl, 42);
      acc_r = 0; acc_l = 0; acc_p = 0; acc_st = 0;
      for (int g = 0; g < 3; g++) begin
         key_in[1] = 1'b1;
         watch(4, 1, fp, fr, fl, np, nr, nl, nst);
         acc_p += np; acc_r += nr; acc_l += nl; acc_st += nst;
         key_in[1] = 1'b0;
         watch(10, 1, fp, fr, fl, np, nr, nl, nst);
         acc_p += np; acc_r += nr; acc_l += nl; acc_st += nst;
      end
      chk("glitch_no_rel", acc_r, 0);
      chk("glitch_no_long", acc_l, 0);
      chk("glitch_no_press", acc_p, 0);
      chk("glitch_state_held", acc_st, 42);
      key_in[1] = 1'b1;
      watch(20, 1, fp, fr, fl, np, nr, nl, nst);
      chk("glitch_final_rel", fr, 11);

      // Reset mid-debounce: db_cnt reaches 5 after edge 8
      key_in[0] = 1'b0;
      watch(8, 0, fp, fr, fl, np, nr, nl, nst);
      chk("mid_no_press", np, 0);
      rstn = 1'b0;
      #1;
      chk("mid_rst_state", int'(key_state), 0);
      chk("mid_rst_pulses", int'(key_press | key_release | key_long), 0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      watch(20, 0, fp, fr, fl, np, nr, nl, nst);
      chk("mid_press_edge", fp, 11);
      chk("mid_press_cnt", np, 1);
      key_in[0] = 1'b1;
      watch(20, 0, fp, fr, fl, np, nr, nl, nst);
      chk("mid_rel_edge", fr, 11);

      chk("mutex_overlap", viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
